mdio_s_phy: RTL
===============

// Module: mdio_s_phy
// PURPOSE
//  MDIO Clause-22 slave (PHY/MMD responder): the far end of the STA master interface.
//  Oversamples MDC and MDIO on the system clock and decodes read/write frames.
//  Writes go to a local 32x16 register-file port; read data is returned on MDIO.
//  Sits between the MDIO pad (mdi in, mdo/mdo_en out) and the PHY register bank.
// PARAMETERS
//  PHY_ADDR      5'd1  PHYAD this slave answers to
//  PREAMBLE_LEN  32    consecutive '1' bits needed before a start (1..32)
//  SYNC_STAGES   2     synchronizer flops on mdc and mdi (>=2)
// PORTS
//  clk        in   1   system clock; must be >= 8x the MDC frequency
//  rst_n      in   1   asynchronous active-low reset
//  mdc        in   1   MDIO clock from the STA (asynchronous to clk)
//  mdi        in   1   MDIO pad input
//  mdo        out  1   MDIO pad output data
//  mdo_en     out  1   MDIO pad output enable (1 = slave drives the line)
//  reg_addr   out  5   REGAD of the current frame
//  reg_rd_en  out  1   one-clk read strobe
//  reg_rdata  in   16  register data, valid the clk after reg_rd_en
//  reg_wr_en  out  1   one-clk write strobe
//  reg_wdata  out  16  write data, valid with reg_wr_en
//  frame_err  out  1   one-clk pulse on a malformed frame (bad ST, OP or write TA)
// BEHAVIOUR
//  Clocking and reset:
//   - Single clock clk; reset is asynchronous, active-low (rst_n).
//   - Reset values: mdo=1, mdo_en=0, reg_*_en=0, reg_addr=0, reg_wdata=0, frame_err=0.
//   - On reset the FSM goes to S_PRE and the preamble count clears to 0.
//   - Reset asserted mid-frame releases mdo_en immediately (async).
//  Sampling:
//   - mdc and mdi pass through SYNC_STAGES flops each.
//   - An MDC rising edge ("rise") is synced mdc going 0->1. On rise, the synced mdi is the bit.
//   - All FSM steps and output updates happen on clk cycles where rise=1.
//  States: S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_WDATA, S_RDATA; 5-bit bit counter.
//   - S_PRE: bit=1 increments the count (saturates at PREAMBLE_LEN); bit=0 clears it.
//     A 0 when count==PREAMBLE_LEN -> S_ST (this is the ST0 bit).
//   - S_ST: bit=1 -> S_OP. bit=0 -> frame_err, then S_PRE with count 0.
//   - S_OP: 2 bits MSB first. 10 = read, 01 = write -> S_PHY. 00/11 -> frame_err, then S_PRE.
//   - S_PHY: 5 bits MSB first. On mismatch with PHY_ADDR -> S_PRE with count 0.
//     This is silent: no frame_err and no drive.
//   - S_REG: 5 bits shifted into reg_addr. On the 5th bit -> S_TA.
//     For a read, reg_rd_en pulses in that same clk.
//   - S_TA, read: mdo_en stays 0 through the rise ending TA1. On that rise, drive mdo=0 and mdo_en=1 (TA2).
//   - S_TA, write: expect bits 1 then 0. Any mismatch -> frame_err, then S_PRE.
//   - S_RDATA: reg_rdata is latched into a shift register the clk after reg_rd_en.
//     On each of the next 16 rises, drive mdo=D15..D0 (changes only on rise).
//     The STA samples on the following MDC falling edge.
//     On the rise after D0: mdo_en=0, mdo=1, then S_PRE with count 0.
//   - S_WDATA: shift in 16 bits MSB first. On the 16th rise, reg_wdata is updated and reg_wr_en pulses 1 clk.
//     Then S_PRE with count 0.
//  Boundary cases:
//   - Frames may run back-to-back; the preamble count starts at 0 after every frame end.
//   - An MDC stall mid-frame holds state indefinitely (no timeout).
//   - reg_rd_en and reg_wr_en are never high in the same clk.
//   - mdo_en is high only from TA2 through D0 of a matching read.
// TESTING
//  1. Read: 32x'1', ST=01, OP=10, PHYAD=1, REGAD=5'h03, reg_rdata=16'hA5C3
//     -> reg_rd_en x1 with reg_addr=3; mdo_en rises at TA2 with mdo=0.
//     -> STA captures 0xA5C3; mdo_en=0 after D0.
//  2. Write: OP=01, PHYAD=1, REGAD=5'h1F, TA=10, data=16'h1234
//     -> exactly one reg_wr_en with reg_addr=0x1F, reg_wdata=0x1234; mdo_en stays 0.
//  3. PHYAD=2 read, then a PHYAD=1 read back-to-back
//     -> no strobe and no drive for the first; the second is serviced normally.
//  4. Preamble of only 31 ones, then a valid frame -> ignored.
//     A 0 inside the preamble restarts the count.
//  5. OP=11 -> one frame_err pulse, no strobes; the next valid frame works.
//     Write with TA=00 -> frame_err and no reg_wr_en.
//  6. rst_n low during D8 of a read -> mdo_en=0 immediately, outputs at reset values.
//     After release, a full read of REGAD=0 succeeds.

Source files
------------

// File: rtl/mdio_s_phy.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_s_phy
//  Description : MDIO Clause-22 slave. Oversamples MDC/MDI on clk, decodes
//                read/write frames addressed to PHY_ADDR, strobes a local
//                32x16 register-file port and returns read data on MDIO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_s_phy #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_LEN = 32,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdi,
    output logic        mdo,
    output logic        mdo_en,
    output logic [4:0]  reg_addr,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr_en,
    output logic [15:0] reg_wdata,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_PRE   = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHY   = 3'd3,
        S_REG   = 3'd4,
        S_TA    = 3'd5,
        S_WDATA = 3'd6,
        S_RDATA = 3'd7
    } state_t;

    // Preamble counter must hold 0..32 inclusive, hence 6 bits.
    localparam logic [5:0] c_PRE_MAX = 6'(PREAMBLE_LEN);

    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdi_sync;
    logic                   r_mdc_prev;
    logic                   w_rise;
    logic                   w_bit;

    state_t      r_state,    w_state_nxt;
    logic [5:0]  r_pre_cnt,  w_pre_nxt;
    logic [4:0]  r_bit_cnt,  w_bcnt_nxt;
    logic        r_is_read,  w_is_read_nxt;
    logic [4:0]  r_phy_shift, w_phy_nxt;
    logic [15:0] r_shift,    w_shift_nxt;
    logic        r_rd_pend;

    logic        w_mdo_nxt;
    logic        w_mdo_en_nxt;
    logic [4:0]  w_addr_nxt;
    logic        w_rd_en_nxt;
    logic        w_wr_en_nxt;
    logic [15:0] w_wdata_nxt;
    logic        w_err_nxt;
    logic [4:0]  w_phy_word;
    logic [4:0]  w_addr_word;
    logic [15:0] w_data_word;

    assign w_rise      = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_prev;
    assign w_bit       = r_mdi_sync[SYNC_STAGES-1];
    assign w_phy_word  = {r_phy_shift[3:0], w_bit};
    assign w_addr_word = {reg_addr[3:0], w_bit};
    assign w_data_word = {r_shift[14:0], w_bit};

    // Bring the asynchronous MDC/MDI pins into the clk domain and keep the
    // previous synced MDC for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdc_sync <= '0;
            r_mdi_sync <= '1;
            r_mdc_prev <= 1'b0;
        end else begin
            r_mdc_sync <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
            r_mdi_sync <= {r_mdi_sync[SYNC_STAGES-2:0], mdi};
            r_mdc_prev <= r_mdc_sync[SYNC_STAGES-1];
        end
    end

    // State register plus all frame-tracking and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_PRE;
            r_pre_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_is_read   <= 1'b0;
            r_phy_shift <= '0;
            r_shift     <= '0;
            r_rd_pend   <= 1'b0;
            mdo         <= 1'b1;
            mdo_en      <= 1'b0;
            reg_addr    <= '0;
            reg_rd_en   <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wdata   <= '0;
            frame_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_nxt;
            r_bit_cnt   <= w_bcnt_nxt;
            r_is_read   <= w_is_read_nxt;
            r_phy_shift <= w_phy_nxt;
            r_shift     <= w_shift_nxt;
            r_rd_pend   <= reg_rd_en;
            mdo         <= w_mdo_nxt;
            mdo_en      <= w_mdo_en_nxt;
            reg_addr    <= w_addr_nxt;
            reg_rd_en   <= w_rd_en_nxt;
            reg_wr_en   <= w_wr_en_nxt;
            reg_wdata   <= w_wdata_nxt;
            frame_err   <= w_err_nxt;
        end
    end

    // Frame decoder: advances only on a synced MDC rising edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_nxt     = r_pre_cnt;
        w_bcnt_nxt    = r_bit_cnt;
        w_is_read_nxt = r_is_read;
        w_phy_nxt     = r_phy_shift;
        w_shift_nxt   = r_shift;
        w_mdo_nxt     = mdo;
        w_mdo_en_nxt  = mdo_en;
        w_addr_nxt    = reg_addr;
        w_wdata_nxt   = reg_wdata;
        w_rd_en_nxt   = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_err_nxt     = 1'b0;

        // Register file answers one clk after the read strobe.
        if (r_rd_pend) begin
            w_shift_nxt = reg_rdata;
        end

        if (w_rise) begin
            case (r_state)
                S_PRE: begin
                    if (w_bit) begin
                        if (r_pre_cnt != c_PRE_MAX) begin
                            w_pre_nxt = r_pre_cnt + 6'd1;
                        end
                    end else if (r_pre_cnt == c_PRE_MAX) begin
                        w_state_nxt = S_ST;
                        w_pre_nxt   = '0;
                    end else begin
                        w_pre_nxt = '0;
                    end
                end
                S_ST: begin
                    if (w_bit) begin
                        w_state_nxt = S_OP;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_PRE;
                        w_pre_nxt   = '0;
                    end
                end
                S_OP: begin
                    // First OP bit is 1 for a read, 0 for a write; the second
                    // bit must be its complement.
                    if (r_bit_cnt == 5'd0) begin
                        w_is_read_nxt = w_bit;
                        w_bcnt_nxt    = 5'd1;
                    end else if (r_is_read != w_bit) begin
                        w_state_nxt = S_PHY;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_PRE;
                        w_pre_nxt   = '0;
                    end
                end
                S_PHY: begin
                    w_phy_nxt = w_phy_word;
                    if (r_bit_cnt == 5'd4) begin
                        w_bcnt_nxt = '0;
                        if (w_phy_word == PHY_ADDR) begin
                            w_state_nxt = S_REG;
                        end else begin
                            w_state_nxt = S_PRE;
                            w_pre_nxt   = '0;
                        end
                    end else begin
                        w_bcnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
                S_REG: begin
                    w_addr_nxt = w_addr_word;
                    if (r_bit_cnt == 5'd4) begin
                        w_state_nxt = S_TA;
                        w_bcnt_nxt  = '0;
                        w_rd_en_nxt = r_is_read;
                    end else begin
                        w_bcnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
                S_TA: begin
                    if (r_is_read) begin
                        // Rise ending TA1: take the line and drive TA2 low.
                        w_mdo_nxt    = 1'b0;
                        w_mdo_en_nxt = 1'b1;
                        w_state_nxt  = S_RDATA;
                        w_bcnt_nxt   = '0;
                    end else if (r_bit_cnt == 5'd0) begin
                        if (w_bit) begin
                            w_bcnt_nxt = 5'd1;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_PRE;
                            w_pre_nxt   = '0;
                        end
                    end else begin
                        if (!w_bit) begin
                            w_state_nxt = S_WDATA;
                            w_bcnt_nxt  = '0;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_PRE;
                            w_pre_nxt   = '0;
                        end
                    end
                end
                S_RDATA: begin
                    if (r_bit_cnt == 5'd16) begin
                        w_mdo_nxt    = 1'b1;
                        w_mdo_en_nxt = 1'b0;
                        w_state_nxt  = S_PRE;
                        w_pre_nxt    = '0;
                        w_bcnt_nxt   = '0;
                    end else begin
                        w_mdo_nxt   = r_shift[15];
                        w_shift_nxt = {r_shift[14:0], 1'b0};
                        w_bcnt_nxt  = r_bit_cnt + 5'd1;
                    end
                end
                S_WDATA: begin
                    w_shift_nxt = w_data_word;
                    if (r_bit_cnt == 5'd15) begin
                        w_wdata_nxt = w_data_word;
                        w_wr_en_nxt = 1'b1;
                        w_state_nxt = S_PRE;
                        w_pre_nxt   = '0;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_PRE;
                    w_pre_nxt   = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
